// File: rtl/riscv_v_exe_sequencer.sv
// Strip-mining sequencer: splits one vector instruction into datapath-width beats with element masks.
// Define RISCV_V_SEQ_PERF_EN to add the perf_beats / perf_stalls counter ports.
module riscv_v_exe_sequencer #(
  parameter int DP_WIDTH    = 128,
  parameter int VL_W        = 8,
  parameter int MAX_BEATS_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_vsew,
  input  logic [VL_W-1:0]           in_vl,
  input  logic [VL_W-1:0]           in_vstart,
  output logic                      beat_valid,
  input  logic                      beat_ready,
  output logic [MAX_BEATS_W-1:0]    beat_idx,
  output logic [VL_W-1:0]           beat_elem_base,
  output logic [DP_WIDTH/8-1:0]     beat_elem_mask,
  output logic [1:0]                beat_sew,
  output logic                      beat_last,
  output logic                      seq_busy,
  output logic                      seq_done,
  output logic                      seq_illegal
`ifdef RISCV_V_SEQ_PERF_EN
  ,
  output logic [31:0]               perf_beats,
  output logic [31:0]               perf_stalls
`endif
);

  localparam int MASK_W = DP_WIDTH / 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]             state_reg;
  logic [1:0]             sew_reg;
  logic [VL_W-1:0]        vl_reg;
  logic [VL_W-1:0]        vstart_reg;
  logic [VL_W-1:0]        base_reg;
  logic [MAX_BEATS_W-1:0] idx_reg;
  logic                   illegal_reg;

  logic [VL_W:0]   epb;
  logic [VL_W:0]   base_plus_epb;
  logic [VL_W-1:0] in_epb_m1;
  logic [VL_W-1:0] in_base;
  logic            in_empty;
  logic            last;
  logic            beat_fire;

  assign epb           = (VL_W+1)'(MASK_W >> sew_reg);
  // One extra bit so the final-beat test cannot wrap when vl is near the top of its range.
  assign base_plus_epb = {1'b0, base_reg} + epb;
  assign last          = (base_plus_epb >= {1'b0, vl_reg});

  assign in_epb_m1 = VL_W'(MASK_W >> in_vsew[1:0]) - VL_W'(1);
  assign in_base   = in_vstart & ~in_epb_m1;
  assign in_empty  = (in_vl == '0) || (in_vstart >= in_vl);

  assign beat_fire = (state_reg == ISSUE) && beat_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sew_reg     <= '0;
      vl_reg      <= '0;
      vstart_reg  <= '0;
      base_reg    <= '0;
      idx_reg     <= '0;
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (in_vsew[2]) begin
              illegal_reg <= 1'b1;
            end else if (in_empty) begin
              state_reg <= DONE;
            end else begin
              sew_reg    <= in_vsew[1:0];
              vl_reg     <= in_vl;
              vstart_reg <= in_vstart;
              base_reg   <= in_base;
              idx_reg    <= '0;
              state_reg  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (beat_fire) begin
            if (last) begin
              state_reg <= DONE;
            end else begin
              base_reg <= base_plus_epb[VL_W-1:0];
              if (idx_reg != '1) idx_reg <= idx_reg + MAX_BEATS_W'(1);
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state_reg == IDLE);
  assign beat_valid     = (state_reg == ISSUE);
  assign seq_busy       = (state_reg == ISSUE);
  assign seq_done       = (state_reg == DONE);
  assign seq_illegal    = illegal_reg;
  assign beat_idx       = idx_reg;
  assign beat_elem_base = base_reg;
  assign beat_sew       = sew_reg;
  assign beat_last      = beat_valid && last;

  // Lane gi is live when its element lies in [vstart, vl) and the lane exists at this SEW.
  genvar gi;
  generate
    for (gi = 0; gi < MASK_W; gi++) begin : g_mask
      logic [31:0] elem;
      assign elem = 32'(base_reg) + 32'(gi);
      assign beat_elem_mask[gi] = beat_valid && (32'(gi) < 32'(epb)) &&
                                  (elem >= 32'(vstart_reg)) && (elem < 32'(vl_reg));
    end
  endgenerate

`ifdef RISCV_V_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_beats  <= '0;
      perf_stalls <= '0;
    end else begin
      if (beat_fire) perf_beats <= perf_beats + 32'd1;
      if (beat_valid && !beat_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_v_exe_sequencer.sv
// Scoreboard bench for riscv_v_exe_sequencer: a driver queues expected beats, a negedge monitor checks them.
module tb_riscv_v_exe_sequencer;

  localparam int DP_WIDTH = 128;
  localparam int VL_W     = 8;
  localparam int MBW      = 8;
  localparam int MASK_W   = DP_WIDTH / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_vsew;
  logic [VL_W-1:0]   in_vl;
  logic [VL_W-1:0]   in_vstart;
  logic              beat_valid;
  logic              beat_ready = 1'b0;
  logic [MBW-1:0]    beat_idx;
  logic [VL_W-1:0]   beat_elem_base;
  logic [MASK_W-1:0] beat_elem_mask;
  logic [1:0]        beat_sew;
  logic              beat_last;
  logic              seq_busy;
  logic              seq_done;
  logic              seq_illegal;
`ifdef RISCV_V_SEQ_PERF_EN
  logic [31:0]       perf_beats;
  logic [31:0]       perf_stalls;
`endif

  riscv_v_exe_sequencer #(.DP_WIDTH(DP_WIDTH), .VL_W(VL_W), .MAX_BEATS_W(MBW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vsew(in_vsew), .in_vl(in_vl), .in_vstart(in_vstart),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_idx(beat_idx),
    .beat_elem_base(beat_elem_base), .beat_elem_mask(beat_elem_mask), .beat_sew(beat_sew),
    .beat_last(beat_last), .seq_busy(seq_busy), .seq_done(seq_done), .seq_illegal(seq_illegal)
`ifdef RISCV_V_SEQ_PERF_EN
    , .perf_beats(perf_beats), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int base; logic [MASK_W-1:0] mask; int sew; bit last; } beat_t;
  typedef struct { int kind; int n; int sew; int vl; int vstart; } instr_t;  // kind: 0 beats, 1 empty, 2 illegal

  beat_t  beat_q[$];
  instr_t instr_q[$];
  int     tests = 0;
  int     fails = 0;
  int     inflight = 0;
  int     m_beats = 0;
  int     m_stalls = 0;
  bit     done_next = 0;
  bit     ill_next = 0;
  bit     mon_en = 0;
  int     ready_mode = 0;  // 0 always ready, 1 random, 2 held low

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: walk element groups with plain arithmetic and list every beat.
  task automatic model_push(input int sew, input int vl, input int vstart);
    instr_t ins;
    beat_t  b;
    int     epb;
    int     base;
    int     n;
    ins.sew = sew; ins.vl = vl; ins.vstart = vstart; ins.n = 0;
    if (sew > 3) ins.kind = 2;
    else if (vl == 0 || vstart >= vl) ins.kind = 1;
    else begin
      ins.kind = 0;
      epb  = (DP_WIDTH / 8) >> sew;
      base = (vstart / epb) * epb;
      n    = 0;
      while (base < vl) begin
        b.idx  = (n > 255) ? 255 : n;
        b.base = base;
        b.sew  = sew;
        b.mask = '0;
        for (int i = 0; i < epb; i++)
          if (base + i >= vstart && base + i < vl) b.mask[i] = 1'b1;
        b.last = (base + epb >= vl);
        beat_q.push_back(b);
        n++;
        base += epb;
      end
      ins.n = n;
    end
    instr_q.push_back(ins);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       beat_ready = 1'b1;
      1:       beat_ready = ($urandom_range(0, 3) != 0);
      default: beat_ready = 1'b0;
    endcase
  end

  beat_t  mb;
  instr_t mi;
  bit     exp_done;
  bit     exp_ill;

  always @(negedge clk) begin
    if (!mon_en) begin
      beat_q.delete();
      instr_q.delete();
      inflight  = 0;
      done_next = 0;
      ill_next  = 0;
    end else begin
      exp_done  = done_next;
      exp_ill   = ill_next;
      done_next = 0;
      ill_next  = 0;
      check("seq_done", seq_done, exp_done);
      check("seq_illegal", seq_illegal, exp_ill);
      check("in_ready", in_ready, (inflight == 0) && !exp_done);
      check("beat_valid", beat_valid, inflight > 0);
      check("seq_busy", seq_busy, inflight > 0);
      if (inflight == 0) begin
        check("mask_idle", beat_elem_mask, 0);
        check("last_idle", beat_last, 0);
      end else begin
        if (!beat_ready) m_stalls++;
        if (beat_q.size() == 0) begin
          check("beat_q_underflow", 1, 0);
        end else begin
          mb = beat_q[0];
          check("beat_idx", beat_idx, mb.idx);
          check("beat_base", beat_elem_base, mb.base);
          check("beat_mask", beat_elem_mask, mb.mask);
          check("beat_sew", beat_sew, mb.sew);
          check("beat_last", beat_last, mb.last);
          if (beat_ready) begin
            mb = beat_q.pop_front();
            m_beats++;
            inflight--;
            if (inflight == 0) done_next = 1;
          end
        end
      end
      if (in_valid && in_ready) begin
        if (instr_q.size() == 0) begin
          check("instr_q_underflow", 1, 0);
        end else begin
          mi = instr_q.pop_front();
          $display("[TB] accept vsew=%0d vl=%0d vstart=%0d kind=%0d beats=%0d", mi.sew, mi.vl, mi.vstart, mi.kind, mi.n);
          case (mi.kind)
            0:       inflight = mi.n;
            1:       done_next = 1;
            default: ill_next = 1;
          endcase
        end
      end
    end
  end

  task automatic issue(input int sew, input int vl, input int vstart);
    int n;
    model_push(sew, vl, vstart);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_vsew   = 3'(sew);
    in_vl     = VL_W'(vl);
    in_vstart = VL_W'(vstart);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 2000);
    if (!in_ready) check("issue_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_vsew   = 3'($urandom);
    in_vl     = VL_W'($urandom);
    in_vstart = VL_W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_ready && instr_q.size() == 0 && inflight == 0 && !done_next && !ill_next) && n < 3000);
    if (n >= 3000) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_beat_valid"}, beat_valid, 0);
    check({tag, "_seq_busy"}, seq_busy, 0);
    check({tag, "_seq_done"}, seq_done, 0);
    check({tag, "_seq_illegal"}, seq_illegal, 0);
    check({tag, "_beat_idx"}, beat_idx, 0);
    check({tag, "_beat_base"}, beat_elem_base, 0);
    check({tag, "_beat_mask"}, beat_elem_mask, 0);
    check({tag, "_beat_sew"}, beat_sew, 0);
    check({tag, "_beat_last"}, beat_last, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sew;
    int vl;
    int vstart;
    rst = 1'b1; in_valid = 1'b0; in_vsew = '0; in_vl = '0; in_vstart = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;

    ready_mode = 0;
    issue(2, 10, 0);  wait_idle();
    issue(2, 10, 5);  wait_idle();
    ready_mode = 2;
    issue(0, 16, 0);
    repeat (3) @(posedge clk);
    ready_mode = 0;
    wait_idle();
`ifdef RISCV_V_SEQ_PERF_EN
    check("perf_stalls", perf_stalls, 3);
`endif
    issue(0, 0, 0);   wait_idle();
    issue(1, 7, 7);   wait_idle();
    issue(5, 10, 0);  wait_idle();
    issue(3, 255, 0); wait_idle();
    issue(2, 12, 3);
    issue(1, 9, 0);
    wait_idle();

    ready_mode = 1;
    for (int t = 0; t < 150; t++) begin
      sew = $urandom_range(0, 9);
      sew = (sew >= 8) ? 4 + $urandom_range(0, 3) : sew % 4;
      vl  = $urandom_range(0, 255);
      if ($urandom_range(0, 9) < 8) vstart = $urandom_range(0, vl);
      else vstart = $urandom_range(0, 255);
      issue(sew, vl, vstart);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
`ifdef RISCV_V_SEQ_PERF_EN
    check("perf_beats", perf_beats, m_beats);
    check("perf_stalls_total", perf_stalls, m_stalls);
`endif

    ready_mode = 0;
    wait_idle();
    issue(2, 10, 0);
    @(posedge clk); #1;
    check("rst_at_beat1_idx", beat_idx, 1);
    mon_en = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("mid_rst");
    repeat (4) begin
      @(negedge clk);
      check("no_done_after_rst", seq_done, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
